// File: rtl/viterbi_frame_ctrl_if.sv
// Channel-side and decoder-side handshake bundle of the Viterbi frame controller.
// The master modport is the controller; the slave modport is its environment.
interface viterbi_frame_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         symValid;
    logic [1:0]   symData;
    logic         symReady;
    logic         decStart;
    logic         decSymValid;
    logic [1:0]   decData;
    logic         decReady;
    logic         decValid;
    logic         decBit;
    logic [N-1:0] frameData;
    logic         frameValid;
    logic         busy;
    logic         error;

    modport master (
        input  start, symValid, symData, decReady, decValid, decBit,
        output symReady, decStart, decSymValid, decData, frameData, frameValid, busy, error
    );

    modport slave (
        output start, symValid, symData, decReady, decValid, decBit,
        input  symReady, decStart, decSymValid, decData, frameData, frameValid, busy, error
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi decoder: buffers N channel symbols, feeds them to the
// decoder under handshake, assembles the decoded bits and aborts on a decoder stall.
module viterbi_frame_ctrl #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rstN,
    viterbi_frame_ctrl_if.master bus
);
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STRT    = 3'd2,
        FEED    = 3'd3,
        COLLECT = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    sym_cnt_q, sym_cnt_d;
    logic [CW-1:0]    feed_cnt_q, feed_cnt_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [N-1:0][1:0] buf_q, buf_d;
    logic [N-1:0]     frame_q, frame_d;
    logic             frame_valid_q, frame_valid_d;

    logic in_dec, start_ok, sym_acc, dec_xfer, bit_acc, progress, bits_done, wd_hit;
    logic [IW-1:0] sym_idx, feed_idx, bit_idx;
    logic sym_ready, dec_start, dec_sym_valid, busy, err;
    logic [1:0] dec_data;

    assign in_dec    = (state_q == FEED) || (state_q == COLLECT);
    assign start_ok  = bus.start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign sym_acc   = bus.symValid && (state_q == LOAD);
    assign dec_xfer  = bus.decReady && (state_q == FEED);
    assign bit_acc   = bus.decValid && in_dec && (bit_cnt_q != CNT_FULL);
    assign progress  = dec_xfer || bit_acc;
    // Counts the bit accepted this cycle, so a last bit coinciding with the last symbol finishes at once.
    assign bits_done = (bit_cnt_q == CNT_FULL) || (bit_acc && (bit_cnt_q == CNT_LAST));
    assign wd_hit    = in_dec && !progress && (wd_q == WD_LAST);
    assign sym_idx   = sym_cnt_q[IW-1:0];
    assign feed_idx  = feed_cnt_q[IW-1:0];
    assign bit_idx   = bit_cnt_q[IW-1:0];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (sym_acc && (sym_cnt_q == CNT_LAST)) state_d = STRT;
            STRT:    state_d = FEED;
            FEED: begin
                if (wd_hit) state_d = ERR;
                else if (dec_xfer && (feed_cnt_q == CNT_LAST)) state_d = bits_done ? DONE : COLLECT;
            end
            COLLECT: begin
                if (wd_hit)         state_d = ERR;
                else if (bits_done) state_d = DONE;
            end
            DONE, ERR: if (start_ok) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sym_cnt_d  = sym_cnt_q;
        feed_cnt_d = feed_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        wd_d       = wd_q;
        buf_d      = buf_q;
        frame_d    = frame_q;
        if (start_ok) begin
            sym_cnt_d  = '0;
            feed_cnt_d = '0;
            bit_cnt_d  = '0;
            wd_d       = '0;
            frame_d    = '0;
        end
        if (sym_acc) begin
            buf_d[sym_idx] = bus.symData;
            sym_cnt_d      = sym_cnt_q + 1'b1;
        end
        if (dec_xfer) feed_cnt_d = feed_cnt_q + 1'b1;
        if (bit_acc) begin
            frame_d[bit_idx] = bus.decBit;
            bit_cnt_d        = bit_cnt_q + 1'b1;
        end
        if (in_dec) wd_d = progress ? '0 : wd_q + 1'b1;
        frame_valid_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sym_cnt_q     <= '0;
            feed_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            wd_q          <= '0;
            buf_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            sym_cnt_q     <= sym_cnt_d;
            feed_cnt_q    <= feed_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            wd_q          <= wd_d;
            buf_q         <= buf_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    always_comb begin
        sym_ready     = 1'b0;
        dec_start     = 1'b0;
        dec_sym_valid = 1'b0;
        busy          = 1'b0;
        err           = 1'b0;
        dec_data      = 2'b00;
        case (state_q)
            LOAD:    begin sym_ready = 1'b1; busy = 1'b1; end
            STRT:    begin dec_start = 1'b1; busy = 1'b1; end
            FEED:    begin dec_sym_valid = 1'b1; dec_data = buf_q[feed_idx]; busy = 1'b1; end
            COLLECT: busy = 1'b1;
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    assign bus.symReady    = sym_ready;
    assign bus.decStart    = dec_start;
    assign bus.decSymValid = dec_sym_valid;
    assign bus.decData     = dec_data;
    assign bus.busy        = busy;
    assign bus.error       = err;
    assign bus.frameData   = frame_q;
    assign bus.frameValid  = frame_valid_q;
endmodule
